// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: BOOT -> FETCH -> EXEC, with a sticky HALT.
// Define PC_MISALIGN_TRAP_EN to trap taken branches to misaligned targets (adds port misalign).
module pc_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcsel,
  input  logic [PC_W-1:0] target,
  input  logic            stall,
  input  logic            halt,
  input  logic            imem_rdy,
  output logic            imem_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus,
  output logic            instr_valid,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output logic            halted
);

  localparam logic [PC_W-1:0] STEP     = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] LOW_MASK = STEP - 1'b1;

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;
  state_t state;

  logic [PC_W-1:0] tgt_aligned;

  assign pc_plus     = pc + STEP;
  assign tgt_aligned = target & ~LOW_MASK;

`ifdef PC_MISALIGN_TRAP_EN
  logic tgt_misaligned;
  assign tgt_misaligned = |(target & LOW_MASK);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_rdy) begin
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          // halt outranks stall; a stalled instruction never commits its PC
          if (halt) begin
            state       <= HALT;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end else if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (pcsel && tgt_misaligned) begin
              state       <= HALT;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
              misalign    <= 1'b1;
            end else begin
              state       <= FETCH;
              instr_valid <= 1'b0;
              imem_req    <= 1'b1;
              pc          <= pcsel ? tgt_aligned : pc_plus;
            end
`else
            state       <= FETCH;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            pc          <= pcsel ? tgt_aligned : pc_plus;
`endif
          end
        end
        HALT: ;
        default: begin
          state       <= BOOT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized transaction-level check of pc_fetch_unit against an instruction-granular PC model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcsel = 1'b0, stall = 1'b0, halt = 1'b0, imem_rdy = 1'b0;
  logic [31:0] target = '0;
  logic        imem_req, instr_valid, halted;
  logic [31:0] pc, pc_plus;

  logic        w_rst = 1'b1;
  logic        w_imem_rdy = 1'b1;
  logic        w_imem_req, w_instr_valid, w_halted;
  logic [31:0] w_pc, w_pc_plus;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign, w_misalign;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] mpc;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .pcsel(pcsel), .target(target), .stall(stall),
    .halt(halt), .imem_rdy(imem_rdy), .imem_req(imem_req), .pc(pc),
    .pc_plus(pc_plus), .instr_valid(instr_valid),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .halted(halted));

  pc_fetch_unit #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
    .clk(clk), .rst(w_rst), .pcsel(1'b0), .target(32'h0), .stall(1'b0),
    .halt(1'b0), .imem_rdy(w_imem_rdy), .imem_req(w_imem_req), .pc(w_pc),
    .pc_plus(w_pc_plus), .instr_valid(w_instr_valid),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign(w_misalign),
`endif
    .halted(w_halted));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // inputs that the current state must ignore
  task automatic rand_exec_inputs();
    pcsel  = 1'($urandom);
    target = $urandom;
    halt   = 1'($urandom);
    stall  = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_req", 64'(imem_req), 64'h0);
    chk("rst_iv", 64'(instr_valid), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("rst_mis", 64'(misalign), 64'h0);
`endif
    rst = 1'b0;
    mpc = 32'h0;
    chk("boot_req", 64'(imem_req), 64'h0);
    chk("boot_pc", 64'(pc), 64'h0);
    tick();
  endtask

  // One instruction: starts just after entering FETCH, ends just after the commit edge.
  task automatic run_instr(input int w, input int s, input bit sel, input logic [31:0] tgt);
    for (int i = 0; i < w; i++) begin
      imem_rdy = 1'b0;
      rand_exec_inputs();
      chk("fetch_req", 64'(imem_req), 64'h1);
      chk("fetch_pc", 64'(pc), 64'(mpc));
      chk("fetch_iv", 64'(instr_valid), 64'h0);
      tick();
    end
    imem_rdy = 1'b1;
    rand_exec_inputs();
    chk("fetch_req", 64'(imem_req), 64'h1);
    chk("fetch_pc", 64'(pc), 64'(mpc));
    tick();
    for (int j = 0; j < s; j++) begin
      imem_rdy = 1'($urandom);
      stall = 1'b1; halt = 1'b0; pcsel = 1'($urandom); target = $urandom;
      chk("stall_iv", 64'(instr_valid), 64'h1);
      chk("stall_req", 64'(imem_req), 64'h0);
      chk("stall_pc", 64'(pc), 64'(mpc));
      chk("stall_pc_plus", 64'(pc_plus), 64'(mpc + 32'd4));
      tick();
    end
    imem_rdy = 1'($urandom);
    stall = 1'b0; halt = 1'b0; pcsel = sel; target = tgt;
    chk("exec_iv", 64'(instr_valid), 64'h1);
    chk("exec_pc", 64'(pc), 64'(mpc));
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    if (sel && (tgt % 4) != 0) begin
      chk("trap_halted", 64'(halted), 64'h1);
      chk("trap_mis", 64'(misalign), 64'h1);
      chk("trap_pc", 64'(pc), 64'(mpc));
      do_reset();
      return;
    end
`endif
    mpc = sel ? (tgt / 4) * 4 : mpc + 32'd4;
    chk("commit_pc", 64'(pc), 64'(mpc));
    chk("commit_req", 64'(imem_req), 64'h1);
    chk("commit_iv", 64'(instr_valid), 64'h0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("commit_mis", 64'(misalign), 64'h0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, boot, sequential run, memory wait at 8, branches from 0x10
    do_reset();
    run_instr(0, 0, 1'b0, 32'h0);
    run_instr(0, 0, 1'b0, 32'h0);
    run_instr(3, 0, 1'b0, 32'h0);
    run_instr(0, 0, 1'b0, 32'h0);
    chk("at_0x10", 64'(pc), 64'h10);
    run_instr(0, 0, 1'b1, 32'h40);
    run_instr(0, 0, 1'b1, 32'h10);
    run_instr(0, 0, 1'b0, 32'h40);
`ifndef PC_MISALIGN_TRAP_EN
    run_instr(0, 0, 1'b1, 32'h43);
    chk("align_43", 64'(pc), 64'h40);
`endif
    run_instr(0, 0, 1'b1, 32'h40);
    run_instr(0, 0, 1'b1, 32'h40);
    chk("self_loop", 64'(pc), 64'h40);

    // stall twice at 0x20, then halt with stall also high
    run_instr(0, 0, 1'b1, 32'h20);
    imem_rdy = 1'b1; tick();
    for (int j = 0; j < 2; j++) begin
      stall = 1'b1; halt = 1'b0;
      chk("hstall_iv", 64'(instr_valid), 64'h1);
      chk("hstall_pc", 64'(pc), 64'h20);
      tick();
    end
    stall = 1'b1; halt = 1'b1; pcsel = 1'b1; target = 32'h80;
    tick();
    chk("halt_halted", 64'(halted), 64'h1);
    chk("halt_pc", 64'(pc), 64'h20);
    chk("halt_iv", 64'(instr_valid), 64'h0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("halt_mis", 64'(misalign), 64'h0);
`endif
    for (int k = 0; k < 6; k++) begin
      imem_rdy = 1'($urandom);
      rand_exec_inputs();
      tick();
      chk("sticky_halted", 64'(halted), 64'h1);
      chk("sticky_pc", 64'(pc), 64'h20);
      chk("sticky_req", 64'(imem_req), 64'h0);
    end

    // async reset mid-FETCH and mid-EXEC
    do_reset();
    run_instr(0, 0, 1'b0, 32'h0);
    imem_rdy = 1'b0; tick();
    rst = 1'b1; #2;
    chk("async_fetch_pc", 64'(pc), 64'h0);
    chk("async_fetch_req", 64'(imem_req), 64'h0);
    do_reset();
    run_instr(0, 0, 1'b1, 32'h100);
    imem_rdy = 1'b1; stall = 1'b1; halt = 1'b0; tick();
    rst = 1'b1; #2;
    chk("async_exec_pc", 64'(pc), 64'h0);
    chk("async_exec_iv", 64'(instr_valid), 64'h0);
    do_reset();

`ifdef PC_MISALIGN_TRAP_EN
    run_instr(0, 0, 1'b0, 32'h0);
    run_instr(0, 0, 1'b0, 32'h0);
    run_instr(0, 0, 1'b1, 32'h42);
    run_instr(0, 0, 1'b0, 32'h0);
    run_instr(0, 0, 1'b0, 32'h0);
    run_instr(0, 0, 1'b1, 32'h44);
    chk("branch_44", 64'(pc), 64'h44);
`endif

    for (int n = 0; n < 200; n++)
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom), $urandom);

    // wrap-around instance boots at 2^32-4
    w_rst = 1'b0;
    chk("wrap_boot_pc", 64'(w_pc), 64'hFFFF_FFFC);
    tick();
    chk("wrap_pc_plus", 64'(w_pc_plus), 64'h0);
    chk("wrap_fetch_req", 64'(w_imem_req), 64'h1);
    tick();
    chk("wrap_exec_iv", 64'(w_instr_valid), 64'h1);
    tick();
    chk("wrap_commit_pc", 64'(w_pc), 64'h0);
    chk("wrap_halted", 64'(w_halted), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
